uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF sync, mid-bit start qualify, centre-sampled data, stop check.
// Strobe one cycle after stop-bit centre; no backpressure, rx_data held until next good frame.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_cnt, baud_d;
  logic [2:0]  bit_cnt, bit_d;
  logic [7:0]  shift_reg, shift_d;
  logic [7:0]  data_d;
  logic        valid_d, err_d;
  logic        s1, rx_sync, rx_prev;
  logic        start_edge;

  // Synchronizer idles high out of reset so no false start edge is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      s1      <= rx_serial;
      rx_sync <= s1;
      rx_prev <= rx_sync;
    end
  end

  assign start_edge = rx_prev && !rx_sync;
  assign rx_busy    = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_cnt  <= 16'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_cnt  <= baud_d;
      bit_cnt   <= bit_d;
      shift_reg <= shift_d;
      rx_data   <= data_d;
      rx_valid  <= valid_d;
      frame_err <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_cnt + 16'd1;
    bit_d   = bit_cnt;
    shift_d = shift_reg;
    data_d  = rx_data;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        if (start_edge) state_d = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (baud_cnt == HALF_LAST) begin
          baud_d = 16'd0;
          if (!rx_sync) begin
            state_d = DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_d  = 16'd0;
          shift_d = {rx_sync, shift_reg[7:1]};
          if (bit_cnt == 3'd7) state_d = STOP;
          else                 bit_d   = bit_cnt + 3'd1;
        end
      end
      STOP: begin
        // Returning to IDLE at stop-bit centre leaves half a bit for the next start edge.
        if (baud_cnt == BAUD_LAST) begin
          baud_d  = 16'd0;
          state_d = IDLE;
          if (rx_sync) begin
            data_d  = shift_reg;
            valid_d = 1'b1;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = 16'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BAUD_DIV=10: stimulus pushes expected strobes, monitor pops and checks.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, rx_busy;

  uart_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_serial(rx_serial),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_mis = 0;
  int         busy_run = 0;
  int         last_run = 0;
  bit         prev_strobe = 1'b0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest expected entry in kind, data and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rx_valid || frame_err) begin
      n_cmp++;
      if ((rx_valid && frame_err) || prev_strobe) begin
        n_mis++;
        $display("FAIL strobe_shape cyc=%0d: valid=%0b err=%0b prev=%0b, required single exclusive pulse",
                 cyc, rx_valid, frame_err, prev_strobe);
      end
      n_cmp++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_strobe cyc=%0d: valid=%0b err=%0b data=%h, required no strobe",
                 cyc, rx_valid, frame_err, rx_data);
      end else begin
        e = sb.pop_front();
        if (e.err != frame_err || e.err == rx_valid || e.data != rx_data || e.cyc != cyc) begin
          n_mis++;
          $display("FAIL strobe_match: got err=%0b data=%h cyc=%0d, required err=%0b data=%h cyc=%0d",
                   frame_err, rx_data, cyc, e.err, e.data, e.cyc);
        end
      end
    end
    prev_strobe = rx_valid || frame_err;
    if (rx_busy) begin
      busy_run++;
    end else if (busy_run > 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic drive_bit(input logic b, input int n);
    rx_serial = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame of start, 8 data bits LSB first, stop. skew alternates 9/11-cycle bits.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit skew);
    exp_t e;
    logic v;
    int   len;
    e.err  = !stop_bit;
    e.data = stop_bit ? d : last_good;
    e.cyc  = cyc + 98;
    sb.push_back(e);
    for (int j = 0; j < 10; j++) begin
      if (j == 0)      v = 1'b0;
      else if (j == 9) v = stop_bit;
      else             v = d[j-1];
      len = skew ? ((j % 2 == 0) ? 9 : 11) : 10;
      drive_bit(v, len);
    end
    if (stop_bit) last_good = d;
  endtask

  task automatic check_val(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, act, act, req, req);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_rx_data"}, int'(rx_data), 0);
    check_val({tag, "_rx_valid"}, int'(rx_valid), 0);
    check_val({tag, "_frame_err"}, int'(frame_err), 0);
    check_val({tag, "_rx_busy"}, int'(rx_busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rx_serial = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    drive_bit(1'b1, 10);

    // Single good frame.
    send_frame(8'hA5, 1'b1, 1'b0);
    drive_bit(1'b1, 20);
    check_val("a5_pending", sb.size(), 0);
    check_val("a5_busy_len", last_run, 95);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    drive_bit(1'b1, 20);
    check_val("b2b_pending", sb.size(), 0);

    // Framing error followed by a held-low line.
    send_frame(8'h3C, 1'b0, 1'b0);
    drive_bit(1'b0, 50);
    drive_bit(1'b1, 20);
    check_val("ferr_pending", sb.size(), 0);
    check_val("ferr_data_held", int'(rx_data), 8'h55);

    // Short low glitch on idle line.
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 20);
    check_val("glitch_busy_len", last_run, 5);
    send_frame(8'h81, 1'b1, 1'b0);
    drive_bit(1'b1, 20);
    check_val("glitch_next_pending", sb.size(), 0);

    // Reset during data bit 4 of 8'hF0 (remaining bits high, so no new edge).
    drive_bit(1'b0, 10);
    for (int k = 0; k < 4; k++) drive_bit(1'b0, 10);
    drive_bit(1'b1, 2);
    rst = 1'b1;
    drive_bit(1'b1, 1);
    rst = 1'b0;
    check_reset("midreset");
    last_good = 8'h00;
    drive_bit(1'b1, 47);
    drive_bit(1'b1, 20);
    check_val("midreset_pending", sb.size(), 0);
    send_frame(8'h7E, 1'b1, 1'b0);
    drive_bit(1'b1, 20);
    check_val("after_reset_pending", sb.size(), 0);

    // Bit-period jitter: alternating 9/11-cycle bits.
    send_frame(8'hC3, 1'b1, 1'b1);
    drive_bit(1'b1, 20);
    check_val("skew_pending", sb.size(), 0);
    check_val("skew_data", int'(rx_data), 8'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
